// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the memory adapter it feeds:
// FSM state encoding, transfer size codes and the default fairness limit.
package memory_arbiter_pkg;

  // Default number of back-to-back port-0 grants allowed while port 1 waits.
  localparam int unsigned MaxConsecDefault = 4;

  // Transfer size codes as understood by the adapter (10 also means 16-bit).
  localparam logic [1:0] SizeHalf    = 2'b00;
  localparam logic [1:0] SizeByte    = 2'b01;
  localparam logic [1:0] SizeHalfAlt = 2'b10;
  localparam logic [1:0] SizeWord    = 2'b11;

  // Operation codes on the ReadWrite line.
  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StDone
  } arb_state_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters (video, CPU), the arbiter and the
// memory adapter. The arbiter takes the master view; the environment
// (requesters plus adapter) takes the slave view.
interface memory_arbiter_if;

  // Port 0: video fetch.
  logic        P0Req;
  logic [24:0] P0Addr;
  logic [31:0] P0WData;
  logic [1:0]  P0Size;
  logic        P0RW;
  logic        P0Ack;

  // Port 1: CPU.
  logic        P1Req;
  logic [24:0] P1Addr;
  logic [31:0] P1WData;
  logic [1:0]  P1Size;
  logic        P1RW;
  logic        P1Ack;

  // Read data returned to whichever port is acknowledged.
  logic [31:0] RData;

  // Adapter side.
  logic [24:0] MemAddr;
  logic [31:0] MemWData;
  logic [1:0]  MemSize;
  logic        MemRW;
  logic        MemRequest;
  logic        MemReady;
  logic [31:0] MemRData;

  modport master (
    input  P0Req, P0Addr, P0WData, P0Size, P0RW,
    input  P1Req, P1Addr, P1WData, P1Size, P1RW,
    output P0Ack, P1Ack, RData,
    output MemAddr, MemWData, MemSize, MemRW, MemRequest,
    input  MemReady, MemRData
  );

  modport slave (
    output P0Req, P0Addr, P0WData, P0Size, P0RW,
    output P1Req, P1Addr, P1WData, P1Size, P1RW,
    input  P0Ack, P1Ack, RData,
    input  MemAddr, MemWData, MemSize, MemRW, MemRequest,
    output MemReady, MemRData
  );

endinterface

// File: rtl/memory_arbiter.sv
// Two-port memory arbiter. Port 0 (video) has priority, but after MAX_CONSEC
// consecutive port-0 grants with port 1 waiting, port 1 is served once.
// Each transaction: IDLE -> ISSUE (Request high until adapter goes busy)
// -> BUSY (wait for Ready) -> DONE (one-cycle Ack) -> IDLE.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = MaxConsecDefault
) (
  input  logic             PixelClk2,
  input  logic             Reset,
  memory_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(MAX_CONSEC + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_CONSEC);

  arb_state_e      state_q, state_d;
  logic            grant_q, grant_d;  // 0 = port 0, 1 = port 1
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [24:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic            mem_rw_q, mem_rw_d;
  logic            mem_req_q, mem_req_d;
  logic            p0_ack_q, p0_ack_d;
  logic            p1_ack_q, p1_ack_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            pick_p1;
  logic            do_grant;

  // Port 1 wins only when port 0 is silent or port 0 has used up its streak.
  assign pick_p1 = bus.P1Req && (!bus.P0Req || (cnt_q == MaxCnt));

  // Next-state, transaction latching and fairness counter.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_rw_d    = mem_rw_q;
    mem_req_d   = mem_req_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    rdata_d     = rdata_q;
    do_grant    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The adapter has no reset, so never issue until it reports idle.
        if (bus.MemReady && (bus.P0Req || bus.P1Req)) begin
          do_grant  = 1'b1;
          grant_d   = pick_p1;
          mem_req_d = 1'b1;
          state_d   = StIssue;
          if (pick_p1) begin
            mem_addr_d  = bus.P1Addr;
            mem_wdata_d = bus.P1WData;
            mem_size_d  = bus.P1Size;
            mem_rw_d    = bus.P1RW;
          end else begin
            mem_addr_d  = bus.P0Addr;
            mem_wdata_d = bus.P0WData;
            mem_size_d  = bus.P0Size;
            mem_rw_d    = bus.P0RW;
          end
        end
      end
      StIssue: begin
        // Adapter dropping Ready is its acceptance of the request.
        if (!bus.MemReady) begin
          mem_req_d = 1'b0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (bus.MemReady) begin
          rdata_d  = bus.MemRData;
          p0_ack_d = !grant_q;
          p1_ack_d = grant_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Streak counter only tracks port-0 grants made while port 1 is waiting.
    if (!bus.P1Req || (do_grant && pick_p1)) begin
      cnt_d = '0;
    end else if (do_grant && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PixelClk2) begin
    if (Reset) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_rw_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_rw_q    <= mem_rw_d;
      mem_req_q   <= mem_req_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.P0Ack      = p0_ack_q;
  assign bus.P1Ack      = p1_ack_q;
  assign bus.RData      = rdata_q;
  assign bus.MemAddr    = mem_addr_q;
  assign bus.MemWData   = mem_wdata_q;
  assign bus.MemSize    = mem_size_q;
  assign bus.MemRW      = mem_rw_q;
  assign bus.MemRequest = mem_req_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed requester stimulus, a behavioural
// adapter returning 0xDEADBDEF + address, and a scoreboard of expected
// (port, read data) acks checked by an independent monitor.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic clk;
  logic rst;

  memory_arbiter_if bus ();

  memory_arbiter #(
    .MAX_CONSEC(4)
  ) dut (
    .PixelClk2(clk),
    .Reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Adapter model controls.
  int   lat     = 1;
  int   acc_dly = 0;
  bit   hold    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] rdata);
    exp_q.push_back('{port: port, rdata: rdata});
  endtask

  task automatic set_p0(input logic r, input logic [24:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic rw);
    bus.P0Req = r; bus.P0Addr = a; bus.P0WData = wd; bus.P0Size = sz; bus.P0RW = rw;
  endtask

  task automatic set_p1(input logic r, input logic [24:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic rw);
    bus.P1Req = r; bus.P1Addr = a; bus.P1WData = wd; bus.P1Size = sz; bus.P1RW = rw;
  endtask

  // Returns at the negedge of the n-th ack seen.
  task automatic wait_acks(input int n);
    int seen = 0;
    for (int c = 0; c < 400 && seen < n; c++) begin
      @(negedge clk);
      if (bus.P0Ack || bus.P1Ack) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual=%0d acks required=%0d acks", seen, n);
    end
  endtask

  // Behavioural adapter: no reset, Ready low while busy, data = 0xDEADBDEF + addr.
  initial begin
    bit          a_busy = 1'b0;
    int          a_cnt  = 0;
    int          a_acc  = 0;
    logic [24:0] a_addr = '0;
    bus.MemReady = 1'b1;
    bus.MemRData = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!a_busy) begin
        if (hold) begin
          bus.MemReady = 1'b0;
        end else begin
          bus.MemReady = 1'b1;
          if (bus.MemRequest) begin
            if (a_acc < acc_dly) begin
              a_acc++;
            end else begin
              a_acc        = 0;
              bus.MemReady = 1'b0;
              a_busy       = 1'b1;
              a_cnt        = lat;
              a_addr       = bus.MemAddr;
            end
          end
        end
      end else if (a_cnt == 0) begin
        bus.MemReady = 1'b1;
        bus.MemRData = 32'hDEADBDEF + {7'b0, a_addr};
        a_busy       = 1'b0;
      end else begin
        a_cnt--;
      end
    end
  end

  // Monitor: scoreboard on acks plus Mem* stability across each transaction.
  exp_t        mon_e;
  bit          in_txn = 1'b0;
  bit          stab_bad = 1'b0;
  logic [59:0] cap;
  always @(negedge clk) begin
    if (!rst && (bus.P0Ack || bus.P1Ack)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=P0Ack:%0b P1Ack:%0b required=no ack",
                 bus.P0Ack, bus.P1Ack);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_port", 32'({bus.P1Ack, bus.P0Ack}), mon_e.port ? 32'd2 : 32'd1);
        check("ack_rdata", bus.RData, mon_e.rdata);
      end
    end
    if (rst) begin
      in_txn = 1'b0;
    end else if (!in_txn && bus.MemRequest) begin
      in_txn   = 1'b1;
      stab_bad = 1'b0;
      cap      = {bus.MemAddr, bus.MemWData, bus.MemSize, bus.MemRW};
    end else if (in_txn) begin
      if ({bus.MemAddr, bus.MemWData, bus.MemSize, bus.MemRW} !== cap) stab_bad = 1'b1;
      if (bus.P0Ack || bus.P1Ack) begin
        check("mem_stable", 32'(stab_bad), 32'd0);
        in_txn = 1'b0;
      end
    end
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int bad;
    rst = 1'b1;
    set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    set_p1(1'b0, '0, '0, 2'b00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_memrequest", 32'(bus.MemRequest), 32'd0);
    check("rst_acks", 32'({bus.P1Ack, bus.P0Ack}), 32'd0);
    check("rst_rdata", bus.RData, 32'd0);
    check("rst_memaddr", 32'(bus.MemAddr), 32'd0);
    check("rst_memwdata", bus.MemWData, 32'd0);
    check("rst_memsize_rw", 32'({bus.MemSize, bus.MemRW}), 32'd0);
    #1 rst = 1'b0;

    // P1-only word read.
    set_p1(1'b1, 25'h0000100, '0, SizeWord, OpRead);
    push(1'b1, 32'hDEADBEEF);
    wait_acks(1);
    #1 set_p1(1'b0, '0, '0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);

    // P0 byte write with a slow-accepting adapter.
    #1 acc_dly = 2;
    set_p0(1'b1, 25'h0000003, 32'h000000A5, SizeByte, OpWrite);
    push(1'b0, 32'hDEADBDF2);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.MemRequest) break;
    end
    check("wr_memaddr", 32'(bus.MemAddr), 32'h3);
    check("wr_memwdata", bus.MemWData, 32'hA5);
    check("wr_memsize", 32'(bus.MemSize), 32'(SizeByte));
    check("wr_memrw", 32'(bus.MemRW), 32'd1);
    hi = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!bus.MemRequest) break;
      hi++;
    end
    check("req_hold_cycles", 32'(hi), 32'd3);
    check("req_drop_ready_low", 32'(bus.MemReady), 32'd0);
    wait_acks(1);
    #1 set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    acc_dly = 0;
    repeat (2) @(negedge clk);

    // Both continuously: P0 x4 then P1, twice.
    #1 set_p0(1'b1, 25'h0000010, '0, SizeWord, OpRead);
    set_p1(1'b1, 25'h0000200, '0, SizeWord, OpRead);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1'b0, 32'hDEADBDFF);
      push(1'b1, 32'hDEADBFEF);
    end
    wait_acks(10);
    #1 set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    set_p1(1'b0, '0, '0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);

    // Streak of 3, P0 leaves, P1 served and counter clears.
    #1 set_p0(1'b1, 25'h0000010, '0, SizeWord, OpRead);
    set_p1(1'b1, 25'h0000200, '0, SizeWord, OpRead);
    for (int k = 0; k < 3; k++) push(1'b0, 32'hDEADBDFF);
    wait_acks(3);
    #1 set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    push(1'b1, 32'hDEADBFEF);
    wait_acks(1);
    #1 set_p0(1'b1, 25'h0000010, '0, SizeWord, OpRead);
    for (int k = 0; k < 4; k++) push(1'b0, 32'hDEADBDFF);
    push(1'b1, 32'hDEADBFEF);
    wait_acks(5);
    #1 set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    set_p1(1'b0, '0, '0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);

    // Adapter not ready for 20 cycles: nothing issued.
    #1 hold = 1'b1;
    @(negedge clk);
    #1 set_p0(1'b1, 25'h0000020, '0, SizeWord, OpRead);
    push(1'b0, 32'hDEADBE0F);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.MemRequest) bad++;
    end
    check("no_issue_not_ready", 32'(bad), 32'd0);
    #1 hold = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.MemReady) break;
      if (bus.MemRequest) bad++;
    end
    check("issue_on_first_ready", 32'({bus.MemRequest, bad[0]}), 32'd2);
    wait_acks(1);
    #1 set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);

    // Reset during BUSY: abandon, then wait for the adapter before the next grant.
    #1 lat = 8;
    set_p0(1'b1, 25'h0000030, '0, SizeWord, OpRead);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.MemRequest) break;
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!bus.MemRequest) break;
    end
    #1 rst = 1'b1;
    set_p0(1'b0, '0, '0, 2'b00, 1'b0);
    set_p1(1'b1, 25'h0000040, '0, SizeWord, OpRead);
    @(negedge clk);
    check("busy_rst_memrequest", 32'(bus.MemRequest), 32'd0);
    check("busy_rst_acks", 32'({bus.P1Ack, bus.P0Ack}), 32'd0);
    check("busy_rst_rdata", bus.RData, 32'd0);
    check("busy_rst_ready_low", 32'(bus.MemReady), 32'd0);
    #1 rst = 1'b0;
    lat = 1;
    push(1'b1, 32'hDEADBE2F);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.MemReady) break;
      if (bus.MemRequest) bad++;
    end
    check("no_issue_adapter_busy", 32'(bad), 32'd0);
    check("post_rst_issue", 32'(bus.MemRequest), 32'd1);
    check("post_rst_memaddr", 32'(bus.MemAddr), 32'h40);
    wait_acks(1);
    #1 set_p1(1'b0, '0, '0, 2'b00, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
